// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - sequential radix-2 Booth multiplier (FSM + shared fa ripple add/sub).
// Optional build macro BOOTH_ARITH_SKIP_EN: skip ARITH for 00/11 Booth pairs.

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module booth_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   a_reg, m_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;
  logic [CNT_W-1:0] count;

  logic             add_en, sub_en, last;
  logic [WIDTH:0]   b_op, sum, a_sh;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] q_sh;
  logic             q1_sh;

  assign sub_en = q_reg[0] & ~q_1;
  assign add_en = ~q_reg[0] & q_1;
  assign b_op   = sub_en ? ~m_reg : m_reg;
  assign carry[0] = sub_en;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      fa u_fa (
        .a   (a_reg[i]),
        .b   (b_op[i]),
        .cin (carry[i]),
        .s   (sum[i]),
        .cout(carry[i+1])
      );
    end
  endgenerate

  // Top bit has no carry-out: A wraps modulo 2**(WIDTH+1).
  assign sum[WIDTH] = a_reg[WIDTH] ^ b_op[WIDTH] ^ carry[WIDTH];

  assign a_sh  = {a_reg[WIDTH], a_reg[WIDTH:1]};
  assign q_sh  = {a_reg[0], q_reg[WIDTH-1:1]};
  assign q1_sh = q_reg[0];
  assign last  = (count == CNT_W'(1));

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef BOOTH_ARITH_SKIP_EN
          state_nxt = multiplier[0] ? S_ARITH : S_SHIFT;
`else
          state_nxt = S_ARITH;
`endif
        end
      end
      S_ARITH: state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (last) begin
          state_nxt = S_DONE;
        end else begin
`ifdef BOOTH_ARITH_SKIP_EN
          state_nxt = (q_sh[0] == q1_sh) ? S_SHIFT : S_ARITH;
`else
          state_nxt = S_ARITH;
`endif
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= '0;
            q_reg <= multiplier;
            q_1   <= 1'b0;
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            count <= CNT_W'(WIDTH);
          end
        end
        S_ARITH: begin
          if (add_en || sub_en) a_reg <= sum;
        end
        S_SHIFT: begin
          a_reg <= a_sh;
          q_reg <= q_sh;
          q_1   <= q1_sh;
          count <= count - CNT_W'(1);
          // Product is captured on the edge that enters DONE.
          if (last) product <= {a_sh[WIDTH-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule
